alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/rr_arb2.sv | 35 +++
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, arbiter state encoding and opcode legality helper
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB, OP_SLT, OP_NOR, OP_MUL: is_legal_op = 1'b1;
      default: is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signal bundle for alu_arbiter
interface alu_arbiter_if;

  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [3:0]  req0_op;
  logic [4:0]  req0_shamt;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [3:0]  req1_op;
  logic [4:0]  req1_shamt;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_result;
  logic        rsp0_zero;
  logic        rsp0_err;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_result;
  logic        rsp1_zero;
  logic        rsp1_err;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    input  req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_control, alu_shamt,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_shamt,
    output req1_valid, req1_a, req1_b, req1_op, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_control, alu_shamt,
    output alu_result, alu_zero
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-granted tracking
module rr_arb2 #(
  parameter bit INIT_LAST = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic grant_any,
  output logic grant_idx
);

  logic last;

  // Lone requester wins; on a tie the one not served most recently wins.
  always_comb begin
    grant_any = valid0 | valid1;
    if (valid0 && valid1) begin
      grant_idx = ~last;
    end else begin
      grant_idx = valid1;
    end
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last <= INIT_LAST;
    end else if (update) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, one operation in flight
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter bit INIT_LAST   = 1'b1
) (
  input logic          clk,
  input logic          reset_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        grant_any;
  logic        grant_idx;
  logic        owner;
  logic        accept;
  logic        rsp_done;
  logic        sel_legal;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [3:0]  sel_op;
  logic [4:0]  sel_shamt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [4:0]  shamt_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        err_q;

  rr_arb2 #(
    .INIT_LAST (INIT_LAST)
  ) u_rr_arb2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid0    (bus.req0_valid),
    .valid1    (bus.req1_valid),
    .update    (accept),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  // Route the currently granted requester's fields toward the capture registers.
  always_comb begin
    sel_a     = grant_idx ? bus.req1_a     : bus.req0_a;
    sel_b     = grant_idx ? bus.req1_b     : bus.req0_b;
    sel_op    = grant_idx ? bus.req1_op    : bus.req0_op;
    sel_shamt = grant_idx ? bus.req1_shamt : bus.req0_shamt;
    sel_legal = is_legal_op(sel_op);
  end

  // Next state and handshake outputs; everything is held low while reset_n is low.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    rsp_done       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    if (reset_n) begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            accept         = 1'b1;
            bus.req0_ready = ~grant_idx;
            bus.req1_ready = grant_idx;
            // Unsupported opcodes never touch the ALU.
            state_next     = sel_legal ? ST_EXEC : ST_RESP;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            state_next = ST_RESP;
          end
        end
        ST_RESP: begin
          bus.rsp0_valid = ~owner;
          bus.rsp1_valid = owner;
          rsp_done       = owner ? bus.rsp1_ready : bus.rsp0_ready;
          if (rsp_done) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait counter: loaded on accept, counts down while the ALU settles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if (state == ST_EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Operand registers double as the ALU drive, so the ALU only sees changes on a legal accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= OP_ADD;
      shamt_q <= 5'd0;
      owner   <= 1'b0;
    end else if (accept) begin
      owner <= grant_idx;
      if (sel_legal) begin
        a_q     <= sel_a;
        b_q     <= sel_b;
        op_q    <= sel_op;
        shamt_q <= sel_shamt;
      end
    end
  end

  // Response capture: ALU result at the end of EXEC, fixed error response for bad opcodes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept && !sel_legal) begin
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      err_q    <= 1'b1;
    end else if (state == ST_EXEC && cnt == 4'd0) begin
      result_q <= bus.alu_result;
      zero_q   <= bus.alu_zero;
      err_q    <= 1'b0;
    end
  end

  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = op_q;
  assign bus.alu_shamt   = shamt_q;

  assign bus.rsp0_result = result_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp0_err    = err_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp1_zero   = zero_q;
  assign bus.rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  exp_t expq0[$];
  exp_t expq1[$];

  logic        sw_valid;
  logic [3:0]  sw_op;
  logic [31:0] sw_a;
  logic [31:0] sw_b;

  alu_arbiter_if if_m ();
  alu_arbiter_if if_1 ();
  alu_arbiter_if if_4 ();

  alu_arbiter #(.WAIT_CYCLES(2), .INIT_LAST(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(if_m));
  alu_arbiter #(.WAIT_CYCLES(1), .INIT_LAST(1'b1)) dut_w1 (.clk(clk), .reset_n(reset_n), .bus(if_1));
  alu_arbiter #(.WAIT_CYCLES(4), .INIT_LAST(1'b1)) dut_w4 (.clk(clk), .reset_n(reset_n), .bus(if_4));

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b, input logic [4:0] sh);
    case (op)
      OP_AND:  alu_fn = a & b;
      OP_OR:   alu_fn = a | b;
      OP_ADD:  alu_fn = a + b;
      OP_SLL:  alu_fn = a << sh;
      OP_SUB:  alu_fn = a - b;
      OP_SLT:  alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  alu_fn = ~(a | b);
      OP_MUL:  alu_fn = a * b;
      default: alu_fn = 32'd0;
    endcase
  endfunction

  assign if_m.alu_result = alu_fn(if_m.alu_control, if_m.alu_a, if_m.alu_b, if_m.alu_shamt);
  assign if_m.alu_zero   = (if_m.alu_result == 32'd0);

  assign if_1.req0_valid = sw_valid;
  assign if_1.req0_op    = sw_op;
  assign if_1.req0_a     = sw_a;
  assign if_1.req0_b     = sw_b;
  assign if_1.req0_shamt = 5'd0;
  assign if_1.req1_valid = 1'b0;
  assign if_1.req1_op    = 4'd0;
  assign if_1.req1_a     = 32'd0;
  assign if_1.req1_b     = 32'd0;
  assign if_1.req1_shamt = 5'd0;
  assign if_1.rsp0_ready = 1'b1;
  assign if_1.rsp1_ready = 1'b1;
  assign if_1.alu_result = alu_fn(if_1.alu_control, if_1.alu_a, if_1.alu_b, if_1.alu_shamt);
  assign if_1.alu_zero   = (if_1.alu_result == 32'd0);

  assign if_4.req0_valid = sw_valid;
  assign if_4.req0_op    = sw_op;
  assign if_4.req0_a     = sw_a;
  assign if_4.req0_b     = sw_b;
  assign if_4.req0_shamt = 5'd0;
  assign if_4.req1_valid = 1'b0;
  assign if_4.req1_op    = 4'd0;
  assign if_4.req1_a     = 32'd0;
  assign if_4.req1_b     = 32'd0;
  assign if_4.req1_shamt = 5'd0;
  assign if_4.rsp0_ready = 1'b1;
  assign if_4.rsp1_ready = 1'b1;
  assign if_4.alu_result = alu_fn(if_4.alu_control, if_4.alu_a, if_4.alu_b, if_4.alu_shamt);
  assign if_4.alu_zero   = (if_4.alu_result == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit idx, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    if (idx) begin
      if_m.req1_valid = v; if_m.req1_op = op; if_m.req1_a = a; if_m.req1_b = b; if_m.req1_shamt = sh;
    end else begin
      if_m.req0_valid = v; if_m.req0_op = op; if_m.req0_a = a; if_m.req0_b = b; if_m.req0_shamt = sh;
    end
  endtask

  task automatic drop(input bit idx);
    if (idx) if_m.req1_valid = 1'b0;
    else if_m.req0_valid = 1'b0;
  endtask

  task automatic push(input bit idx, input logic [31:0] r, input logic z, input logic e);
    exp_t x;
    x.result = r; x.zero = z; x.err = e;
    if (idx) expq1.push_back(x);
    else expq0.push_back(x);
  endtask

  // Returns at the negedge where the requester's ready is seen high.
  task automatic wait_ready(input bit idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (idx ? if_m.req1_ready : if_m.req0_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (expq0.size() == 0 && expq1.size() == 0) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("drain", done, 1);
  endtask

  task automatic issue(input bit idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] er, input logic ez, input logic ee,
                       input int exp_lat);
    bit ok;
    int lat;
    push(idx, er, ez, ee);
    set_req(idx, 1'b1, op, a, b, sh);
    wait_ready(idx, ok);
    chk("accept", ok, 1);
    @(posedge clk); #1;
    drop(idx);
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (lat == 1 && is_legal_op(op)) begin
        chk("exec_alu_a", if_m.alu_a, a);
        chk("exec_alu_control", if_m.alu_control, op);
      end
      if (idx ? if_m.rsp1_valid : if_m.rsp0_valid) ok = 1'b1;
      else begin lat++; @(posedge clk); #1; end
    end
    chk("latency", lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic tie(input bit exp_first);
    bit ok;
    push(1'b0, 32'd0, 1'b1, 1'b0);
    push(1'b1, 32'd5, 1'b0, 1'b0);
    set_req(1'b0, 1'b1, OP_SUB, 32'd4, 32'd4, 5'd0);
    set_req(1'b1, 1'b1, OP_OR, 32'd4, 32'd1, 5'd0);
    @(negedge clk);
    chk("tie_ready0", if_m.req0_ready, {31'd0, ~exp_first});
    chk("tie_ready1", if_m.req1_ready, {31'd0, exp_first});
    @(posedge clk); #1;
    drop(exp_first);
    wait_ready(~exp_first, ok);
    chk("tie_second_accept", ok, 1);
    @(posedge clk); #1;
    drop(~exp_first);
    drain();
  endtask

  // Scoreboard: every response cycle is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("one_rsp_at_a_time", if_m.rsp0_valid & if_m.rsp1_valid, 0);
      if (if_m.rsp0_valid) begin
        chk("rsp0_expected", expq0.size() > 0, 1);
        if (expq0.size() > 0) begin
          chk("rsp0_result", if_m.rsp0_result, expq0[0].result);
          chk("rsp0_zero", if_m.rsp0_zero, expq0[0].zero);
          chk("rsp0_err", if_m.rsp0_err, expq0[0].err);
          if (if_m.rsp0_ready) void'(expq0.pop_front());
        end
      end
      if (if_m.rsp1_valid) begin
        chk("rsp1_expected", expq1.size() > 0, 1);
        if (expq1.size() > 0) begin
          chk("rsp1_result", if_m.rsp1_result, expq1[0].result);
          chk("rsp1_zero", if_m.rsp1_zero, expq1[0].zero);
          chk("rsp1_err", if_m.rsp1_err, expq1[0].err);
          if (if_m.rsp1_ready) void'(expq1.pop_front());
        end
      end
    end
  end

  logic        pend0, pend1;
  logic [72:0] hold0, hold1;
  wire  [72:0] cur0 = {if_m.req0_op, if_m.req0_a, if_m.req0_b, if_m.req0_shamt};
  wire  [72:0] cur1 = {if_m.req1_op, if_m.req1_a, if_m.req1_b, if_m.req1_shamt};

  // A stalled request must keep its fields until it is accepted.
  always @(negedge clk) begin
    if (pend0 && if_m.req0_valid) chk("req0_hold_stable", cur0 === hold0, 1);
    if (pend1 && if_m.req1_valid) chk("req1_hold_stable", cur1 === hold1, 1);
    pend0 <= if_m.req0_valid & ~if_m.req0_ready;
    pend1 <= if_m.req1_valid & ~if_m.req1_ready;
    hold0 <= cur0;
    hold1 <= cur1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int l1, l4;
    logic [31:0] r1, r4;
    errors = 0;
    checks = 0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    reset_n = 1'b0;
    sw_valid = 1'b0; sw_op = OP_ADD; sw_a = 32'd0; sw_b = 32'd0;
    if_m.rsp0_ready = 1'b1;
    if_m.rsp1_ready = 1'b1;
    set_req(1'b0, 1'b1, OP_ADD, 32'd9, 32'd9, 5'd0);
    set_req(1'b1, 1'b0, OP_ADD, 32'd0, 32'd0, 5'd0);

    // Reset values, with a request pending to show ready stays low.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req0_ready", if_m.req0_ready, 0);
    chk("rst_req1_ready", if_m.req1_ready, 0);
    chk("rst_rsp0_valid", if_m.rsp0_valid, 0);
    chk("rst_rsp1_valid", if_m.rsp1_valid, 0);
    chk("rst_rsp_result", if_m.rsp0_result, 0);
    chk("rst_rsp_zero", if_m.rsp0_zero, 0);
    chk("rst_rsp_err", if_m.rsp0_err, 0);
    chk("rst_alu_a", if_m.alu_a, 0);
    chk("rst_alu_b", if_m.alu_b, 0);
    chk("rst_alu_shamt", if_m.alu_shamt, 0);
    chk("rst_alu_control", if_m.alu_control, 32'(OP_ADD));
    @(posedge clk); #1;
    drop(1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Ties: first after reset and the next one both go to requester 0.
    tie(1'b0);
    tie(1'b0);

    // Single ADD 4+1 with default latency.
    issue(1'b0, OP_ADD, 32'd4, 32'd1, 5'd0, 32'd5, 1'b0, 1'b0, 3);

    // Backpressure on requester 0 while requester 1 waits.
    if_m.rsp0_ready = 1'b0;
    push(1'b0, 32'd32, 1'b0, 1'b0);
    set_req(1'b0, 1'b1, OP_SLL, 32'd4, 32'd0, 5'd3);
    wait_ready(1'b0, ok);
    chk("bp_accept", ok, 1);
    @(posedge clk); #1;
    drop(1'b0);
    push(1'b1, 32'd2, 1'b0, 1'b0);
    set_req(1'b1, 1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (if_m.rsp0_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("bp_rsp_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_rsp0_valid_held", if_m.rsp0_valid, 1);
      chk("bp_req1_ready_low", if_m.req1_ready, 0);
    end
    @(posedge clk); #1;
    if_m.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_req1_ready_at_hs", if_m.req1_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_req1_ready_after", if_m.req1_ready, 1);
    @(posedge clk); #1;
    drop(1'b1);
    drain();

    // Unsupported opcode bypasses the ALU entirely.
    issue(1'b0, 4'b0101, 32'd7, 32'd7, 5'd2, 32'd0, 1'b1, 1'b1, 1);
    chk("illegal_alu_a_hold", if_m.alu_a, 32'd1);
    chk("illegal_alu_shamt_hold", if_m.alu_shamt, 0);
    chk("illegal_alu_control_hold", if_m.alu_control, 32'(OP_ADD));

    // Reset one cycle after an accept discards the operation.
    set_req(1'b0, 1'b1, OP_ADD, 32'd4, 32'd1, 5'd0);
    wait_ready(1'b0, ok);
    chk("mid_accept", ok, 1);
    @(posedge clk); #1;
    drop(1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_alu_a", if_m.alu_a, 0);
    chk("mid_alu_b", if_m.alu_b, 0);
    chk("mid_alu_control", if_m.alu_control, 32'(OP_ADD));
    chk("mid_rsp0_valid", if_m.rsp0_valid, 0);
    chk("mid_rsp_result", if_m.rsp0_result, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    tie(1'b0);

    // Latency sweep on the WAIT_CYCLES=1 and =4 instances.
    sw_op = OP_MUL; sw_a = 32'd3; sw_b = 32'd7; sw_valid = 1'b1;
    @(negedge clk);
    chk("sweep_w1_ready", if_1.req0_ready, 1);
    chk("sweep_w4_ready", if_4.req0_ready, 1);
    @(posedge clk); #1;
    sw_valid = 1'b0;
    l1 = 0; l4 = 0; r1 = 32'hdead; r4 = 32'hdead;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (if_1.rsp0_valid && l1 == 0) begin l1 = k; r1 = if_1.rsp0_result; end
      if (if_4.rsp0_valid && l4 == 0) begin l4 = k; r4 = if_4.rsp0_result; end
      @(posedge clk); #1;
    end
    chk("sweep_w1_latency", l1, 2);
    chk("sweep_w4_latency", l4, 5);
    chk("sweep_w1_result", r1, 32'd21);
    chk("sweep_w4_result", r4, 32'd21);

    repeat (3) begin @(posedge clk); #1; end
    chk("final_q0_empty", expq0.size(), 0);
    chk("final_q1_empty", expq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
